nonrestoring_divider: RTL and testbench

//  Sequential signed divider; inverse companion of the Booth multiplier, same datapath/controller style.

---
 rtl/nonrestoring_divider_if.sv | 31 +++
 rtl/nonrestoring_divider.sv | 208 ++++++++++++++++++++
 tb/tb_nonrestoring_divider.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/nonrestoring_divider_if.sv
// Operand/result bus for the sequential non-restoring divider.
// The master (requester) drives the shared operand bus and start strobe;
// the slave (divider) returns the packed {remainder, quotient} and status flags.
interface nonrestoring_divider_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0]   data_in;
    logic               start;
    logic [2*WIDTH-1:0] result;
    logic               done;
    logic               div0;
    logic               ovf;

    modport master (
        output data_in,
        output start,
        input  result,
        input  done,
        input  div0,
        input  ovf
    );

    modport slave (
        input  data_in,
        input  start,
        output result,
        output done,
        output div0,
        output ovf
    );
endinterface

// File: rtl/nonrestoring_divider.sv
// Sequential signed divider, one quotient bit per clock (non-restoring).
// The divisor and then the dividend arrive serially on the shared operand bus.
// The division runs on unsigned magnitudes; the signs are reapplied at the end.
// The result is packed as {remainder, quotient}, the same layout as the
// Booth multiplier's {A,Q} product.
module nonrestoring_divider #(
    parameter int WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    nonrestoring_divider_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        LDM,
        LDQ,
        PREP,
        ITER,
        FIX,
        SIGN,
        DONE
    } stateT;

    stateT              stateQ, stateD;

    // A carries one extra bit so that its sign survives the shift/add steps.
    logic [WIDTH:0]     aQ, aD;
    logic [WIDTH-1:0]   qQ, qD;
    logic [WIDTH-1:0]   mQ, mD;
    logic [CW-1:0]      cntQ, cntD;
    logic               sqQ, sqD;
    logic               srQ, srD;
    logic [2*WIDTH-1:0] resultQ, resultD;
    logic               div0Q, div0D;
    logic               ovfQ, ovfD;

    logic [WIDTH-1:0]   mMag;
    logic [WIDTH-1:0]   qMag;
    logic [WIDTH:0]     mExt;
    logic [WIDTH:0]     aShift;
    logic [WIDTH:0]     aIter;
    logic [WIDTH:0]     aFix;
    logic [WIDTH-1:0]   quoSigned;
    logic [WIDTH-1:0]   remSigned;

    // Magnitudes stay WIDTH bits unsigned, so the most negative value maps onto 2^(WIDTH-1) with no loss.
    always_comb begin
        mMag = mQ[WIDTH-1] ? -mQ : mQ;
        qMag = qQ[WIDTH-1] ? -qQ : qQ;
    end

    // One non-restoring step: shift {A,Q} left, then subtract M if A was non-negative, else add M.
    always_comb begin
        mExt   = {1'b0, mQ};
        aShift = {aQ[WIDTH-1:0], qQ[WIDTH-1]};
        if (aQ[WIDTH]) begin
            aIter = aShift + mExt;
        end else begin
            aIter = aShift - mExt;
        end
        aFix = aQ[WIDTH] ? (aQ + mExt) : aQ;
    end

    // Reapply signs: the quotient takes sign(n)^sign(d); the remainder takes the dividend's sign.
    always_comb begin
        quoSigned = sqQ ? -qQ : qQ;
        remSigned = srQ ? -(aQ[WIDTH-1:0]) : aQ[WIDTH-1:0];
    end

    // State register; reset returns to IDLE and discards any operation in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state sequencing; start is honoured only while IDLE or DONE.
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE: begin
                if (bus.start) begin
                    stateD = LDM;
                end
            end
            LDM: begin
                stateD = LDQ;
            end
            LDQ: begin
                stateD = PREP;
            end
            PREP: begin
                if (mQ == '0) begin
                    stateD = DONE;
                end else begin
                    stateD = ITER;
                end
            end
            ITER: begin
                if (cntQ == CW'(1)) begin
                    stateD = FIX;
                end
            end
            FIX: begin
                stateD = SIGN;
            end
            SIGN: begin
                stateD = DONE;
            end
            DONE: begin
                if (bus.start) begin
                    stateD = LDM;
                end
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    // Datapath next values: each state touches only the registers it owns.
    always_comb begin
        aD      = aQ;
        qD      = qQ;
        mD      = mQ;
        cntD    = cntQ;
        sqD     = sqQ;
        srD     = srQ;
        resultD = resultQ;
        div0D   = div0Q;
        ovfD    = ovfQ;
        case (stateQ)
            LDM: begin
                mD    = bus.data_in;
                div0D = 1'b0;
                ovfD  = 1'b0;
            end
            LDQ: begin
                qD = bus.data_in;
                aD = '0;
            end
            PREP: begin
                sqD  = qQ[WIDTH-1] ^ mQ[WIDTH-1];
                srD  = qQ[WIDTH-1];
                mD   = mMag;
                qD   = qMag;
                cntD = CW'(WIDTH);
                if (mQ == '0) begin
                    resultD = {qQ, {WIDTH{1'b1}}};
                    div0D   = 1'b1;
                end
            end
            ITER: begin
                aD   = aIter;
                qD   = {qQ[WIDTH-2:0], ~aIter[WIDTH]};
                cntD = cntQ - CW'(1);
            end
            FIX: begin
                aD = aFix;
            end
            SIGN: begin
                resultD = {remSigned, quoSigned};
                ovfD    = ~sqQ & qQ[WIDTH-1];
            end
            default: begin
            end
        endcase
    end

    // Datapath registers, synchronously cleared so that no partial result survives a reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            aQ      <= '0;
            qQ      <= '0;
            mQ      <= '0;
            cntQ    <= '0;
            sqQ     <= 1'b0;
            srQ     <= 1'b0;
            resultQ <= '0;
            div0Q   <= 1'b0;
            ovfQ    <= 1'b0;
        end else begin
            aQ      <= aD;
            qQ      <= qD;
            mQ      <= mD;
            cntQ    <= cntD;
            sqQ     <= sqD;
            srQ     <= srD;
            resultQ <= resultD;
            div0Q   <= div0D;
            ovfQ    <= ovfD;
        end
    end

    // Outputs are taken straight from registers; done is decoded from the DONE state alone.
    always_comb begin
        bus.result = resultQ;
        bus.done   = (stateQ == DONE);
        bus.div0   = div0Q;
        bus.ovf    = ovfQ;
    end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Scoreboard testbench for nonrestoring_divider.
// The driver issues operations and pushes the reference result.
// A monitor pops an entry whenever done rises and compares result, div0 and ovf.
module tb_nonrestoring_divider;

    localparam int W = 16;

    typedef struct {
        logic [2*W-1:0] result;
        logic           div0;
        logic           ovf;
    } expT;

    logic clk;
    logic rst_n;
    int   compared   = 0;
    int   mismatched = 0;
    expT  sb[$];
    expT  monE;
    logic prevDone = 1'b0;

    nonrestoring_divider_if #(.WIDTH(W)) bus ();

    nonrestoring_divider #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: integer division truncates toward zero, and the remainder takes the dividend's sign.
    function automatic expT refModel(input int n, input int d);
        expT e;
        int  q;
        int  r;
        if (d == 0) begin
            e.result = {n[15:0], 16'hFFFF};
            e.div0   = 1'b1;
            e.ovf    = 1'b0;
        end else begin
            q        = n / d;
            r        = n % d;
            e.result = {r[15:0], q[15:0]};
            e.div0   = 1'b0;
            e.ovf    = (q > 32767);
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Runs one division. holdCycles keeps start high past E0 to confirm it is ignored while busy.
    task automatic applyStimulus(input logic signed [W-1:0] divisor,
                                 input logic signed [W-1:0] dividend,
                                 input int holdCycles);
        int latency;
        int expLat;
        bit gotDone;
        sb.push_back(refModel(int'(dividend), int'(divisor)));
        expLat  = (divisor == 0) ? 3 : 21;
        latency = 0;
        gotDone = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 60 && !gotDone; k++) begin
            bus.start = (k <= holdCycles);
            if (k == 1) begin
                bus.data_in = divisor;
            end else if (k == 2) begin
                bus.data_in = dividend;
            end else begin
                bus.data_in = W'($urandom);
            end
            @(posedge clk); #1;
            if (bus.done) begin
                gotDone = 1'b1;
                latency = k;
            end
        end
        bus.start = 1'b0;
        checkOutput($sformatf("latency %0d/%0d", dividend, divisor), 32'(latency), 32'(expLat));
    endtask

    // Monitor: each rising edge of done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.done && !prevDone) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_done: got result 0x%08h, expected no completion", bus.result);
            end else begin
                monE = sb.pop_front();
                checkOutput("result", bus.result, monE.result);
                checkOutput("div0", 32'(bus.div0), 32'(monE.div0));
                checkOutput("ovf", 32'(bus.ovf), 32'(monE.ovf));
            end
        end
        prevDone <= bus.done;
    end

    initial begin
        logic signed [W-1:0] d;
        logic signed [W-1:0] n;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_result", bus.result, 32'd0);
        checkOutput("reset_div0", 32'(bus.div0), 32'd0);
        checkOutput("reset_ovf", 32'(bus.ovf), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(16'sd7, 16'sd100, 0);
        applyStimulus(16'sd7, -16'sd100, 0);
        applyStimulus(-16'sd7, 16'sd100, 0);
        applyStimulus(16'sd5, 16'sd0, 0);
        applyStimulus(-16'sd1, -16'sd32768, 0);
        applyStimulus(16'sd1, -16'sd32768, 0);
        applyStimulus(16'sd0, 16'sd7, 0);

        // Abort 100/7 with a reset sampled at E10.
        bus.start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 9; k++) begin
            bus.start   = 1'b0;
            bus.data_in = (k == 1) ? 16'd7 : (k == 2) ? 16'd100 : W'($urandom);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort_done", 32'(bus.done), 32'd0);
        checkOutput("abort_result", bus.result, 32'd0);
        checkOutput("abort_div0", 32'(bus.div0), 32'd0);
        checkOutput("abort_ovf", 32'(bus.ovf), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(16'sd7, 16'sd100, 0);
        applyStimulus(16'sd16, 16'sd255, 4);
        applyStimulus(16'sd3, 16'sd32767, 0);
        applyStimulus(-16'sd32768, 16'sd32767, 0);
        applyStimulus(-16'sd32768, -16'sd32768, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0:       d = 16'sd0;
                1:       d = -16'sd1;
                2:       d = 16'sd1;
                3:       d = W'($urandom_range(1, 20));
                4:       d = -W'($urandom_range(1, 20));
                default: d = W'($urandom);
            endcase
            n = ($urandom_range(0, 7) == 0) ? -16'sd32768 : W'($urandom);
            applyStimulus(d, n, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
